// File: rtl/instr_mem_access.sv
// ---------------------------------------------------------------------------
// instr_mem_access
//
// Memory-access stage of the RV32I pipeline, sitting between execute and
// write-back. Non-memory results pass straight through with one cycle of
// latency. Loads and stores run a req/ack transaction on the data-memory
// port while the stage holds the upstream pipeline via stall_out. Loads are
// sign- or zero-extended from the addressed lane, and stores are steered to
// the addressed byte lanes.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   ex_valid          execute-stage outputs valid this cycle
//   instruction_in    instruction from execute
//   alu_in            ALU result or effective address
//   mem_data_in       store data (rs2)
//   stall_out         combinational hold request to upstream
//   dmem_req/we/addr/be/wdata   registered data-memory request
//   dmem_rdata, dmem_ack        data-memory response
//   wb_valid_out      write-back slot valid
//   instruction_out   instruction to write-back (NOP for bubbles/faults)
//   wb_data_out       result to write-back
//   misalign_out      misaligned access or illegal funct3 (one-cycle pulse)
//   bus_err_out       dmem timeout (one-cycle pulse)
// ---------------------------------------------------------------------------
module instr_mem_access #(
    parameter int          XLEN    = 32,
    parameter int          TIMEOUT = 16,
    parameter logic [31:0] NOP     = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] instruction_in,
    input  logic [XLEN-1:0] alu_in,
    input  logic [XLEN-1:0] mem_data_in,
    output logic            stall_out,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [3:0]      dmem_be,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic [XLEN-1:0] dmem_rdata,
    input  logic            dmem_ack,
    output logic            wb_valid_out,
    output logic [XLEN-1:0] instruction_out,
    output logic [XLEN-1:0] wb_data_out,
    output logic            misalign_out,
    output logic            bus_err_out
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            req_q, req_d;
    logic            we_q, we_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [3:0]      be_q, be_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] opInstr_q, opInstr_d;
    logic [1:0]      lane_q, lane_d;
    logic            wbValid_q, wbValid_d;
    logic [XLEN-1:0] instrOut_q, instrOut_d;
    logic [XLEN-1:0] wbData_q, wbData_d;
    logic            misalign_q, misalign_d;
    logic            busErr_q, busErr_d;

    logic [2:0]      funct3;
    logic            isLoad, isStore, f3Legal, misaligned, memOp, memGo;
    logic [3:0]      beNew;
    logic [XLEN-1:0] wdataNew;
    logic [7:0]      byteVal;
    logic [15:0]     halfVal;
    logic [XLEN-1:0] loadVal;

    // Decode of the instruction presented by execute. funct3[1:0] gives the
    // access size for both loads and stores; funct3[2] is the unsigned flag.
    always_comb begin
        funct3   = instruction_in[14:12];
        isLoad   = (instruction_in[6:0] == OP_LOAD);
        isStore  = (instruction_in[6:0] == OP_STORE);
        f3Legal  = isLoad ? (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                          : (funct3 inside {3'b000, 3'b001, 3'b010});
        misaligned = ((funct3[1:0] == 2'b01) && alu_in[0]) ||
                     ((funct3[1:0] == 2'b10) && (alu_in[1:0] != 2'b00));
        memOp    = ex_valid && (isLoad || isStore);
        memGo    = memOp && f3Legal && !misaligned;
    end

    // Store lane steering: narrow data is replicated across the word so the
    // byte enables alone select which lanes memory writes.
    always_comb begin
        beNew    = 4'b1111;
        wdataNew = '0;
        if (isStore) begin
            case (funct3[1:0])
                2'b00: begin
                    beNew    = 4'b0001 << alu_in[1:0];
                    wdataNew = {(XLEN/8){mem_data_in[7:0]}};
                end
                2'b01: begin
                    beNew    = 4'b0011 << alu_in[1:0];
                    wdataNew = {(XLEN/16){mem_data_in[15:0]}};
                end
                default: begin
                    beNew    = 4'b1111;
                    wdataNew = mem_data_in;
                end
            endcase
        end
    end

    // Load lane extraction uses the address bits latched at acceptance, since
    // dmem_addr itself is word aligned.
    always_comb begin
        byteVal = dmem_rdata[{lane_q, 3'b000} +: 8];
        halfVal = dmem_rdata[{lane_q[1], 4'b0000} +: 16];
        case (opInstr_q[14:12])
            3'b000:  loadVal = {{(XLEN-8){byteVal[7]}}, byteVal};
            3'b001:  loadVal = {{(XLEN-16){halfVal[15]}}, halfVal};
            3'b010:  loadVal = dmem_rdata;
            3'b100:  loadVal = {{(XLEN-8){1'b0}}, byteVal};
            3'b101:  loadVal = {{(XLEN-16){1'b0}}, halfVal};
            default: loadVal = '0;
        endcase
    end

    // Next-state and output logic. The write-back slot defaults to a bubble
    // every cycle; the fault flags are therefore single-cycle pulses. In BUSY
    // the request fields are left untouched so they stay stable until the
    // transaction ends.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        opInstr_d  = opInstr_q;
        lane_d     = lane_q;
        wbValid_d  = 1'b0;
        instrOut_d = XLEN'(NOP);
        wbData_d   = wbData_q;
        misalign_d = 1'b0;
        busErr_d   = 1'b0;
        stall_out  = 1'b0;

        case (state_q)
            IDLE: begin
                if (memGo) begin
                    stall_out = 1'b1;
                    req_d     = 1'b1;
                    we_d      = isStore;
                    addr_d    = {alu_in[XLEN-1:2], 2'b00};
                    be_d      = beNew;
                    wdata_d   = wdataNew;
                    opInstr_d = instruction_in;
                    lane_d    = alu_in[1:0];
                    cnt_d     = '0;
                    state_d   = BUSY;
                end else if (memOp) begin
                    wbValid_d  = 1'b1;
                    misalign_d = 1'b1;
                    wbData_d   = alu_in;
                end else if (ex_valid) begin
                    wbValid_d  = 1'b1;
                    instrOut_d = instruction_in;
                    wbData_d   = alu_in;
                end
            end
            BUSY: begin
                stall_out = 1'b1;
                if (dmem_ack) begin
                    req_d      = 1'b0;
                    state_d    = IDLE;
                    wbValid_d  = 1'b1;
                    instrOut_d = opInstr_q;
                    wbData_d   = we_q ? '0 : loadVal;
                end else if (cnt_q == CNT_LAST) begin
                    req_d     = 1'b0;
                    state_d   = IDLE;
                    wbValid_d = 1'b1;
                    busErr_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            be_q       <= 4'b0000;
            wdata_q    <= '0;
            opInstr_q  <= XLEN'(NOP);
            lane_q     <= 2'b00;
            wbValid_q  <= 1'b0;
            instrOut_q <= XLEN'(NOP);
            wbData_q   <= '0;
            misalign_q <= 1'b0;
            busErr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            opInstr_q  <= opInstr_d;
            lane_q     <= lane_d;
            wbValid_q  <= wbValid_d;
            instrOut_q <= instrOut_d;
            wbData_q   <= wbData_d;
            misalign_q <= misalign_d;
            busErr_q   <= busErr_d;
        end
    end

    assign dmem_req        = req_q;
    assign dmem_we         = we_q;
    assign dmem_addr       = addr_q;
    assign dmem_be         = be_q;
    assign dmem_wdata      = wdata_q;
    assign wb_valid_out    = wbValid_q;
    assign instruction_out = instrOut_q;
    assign wb_data_out     = wbData_q;
    assign misalign_out    = misalign_q;
    assign bus_err_out     = busErr_q;

endmodule

// File: tb/tb_instr_mem_access.sv
// ---------------------------------------------------------------------------
// tb_instr_mem_access
//
// Directed testbench for instr_mem_access. Each scenario task drives its own
// stimulus and compares outputs against hand-computed values. Inputs change
// 1ns after the rising edge; outputs are sampled at that point or 1ns later.
// ---------------------------------------------------------------------------
module tb_instr_mem_access;

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] ADDI  = 32'h0050_0093;
    localparam logic [31:0] I_LB  = 32'h0000_0083;
    localparam logic [31:0] I_LBU = 32'h0000_4083;
    localparam logic [31:0] I_LW  = 32'h0000_2083;
    localparam logic [31:0] I_LHU = 32'h0000_5083;
    localparam logic [31:0] I_L11 = 32'h0000_3083;
    localparam logic [31:0] I_SB  = 32'h0000_0023;
    localparam logic [31:0] I_SH  = 32'h0000_1023;
    localparam logic [31:0] I_SW  = 32'h0000_2023;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [31:0] instruction_in, alu_in, mem_data_in;
    logic        stall_out, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic        wb_valid_out;
    logic [31:0] instruction_out, wb_data_out;
    logic        misalign_out, bus_err_out;

    int checks   = 0;
    int failures = 0;

    instr_mem_access #(.XLEN(32), .TIMEOUT(16), .NOP(NOP)) dut (
        .clk             (clk),
        .rst             (rst),
        .ex_valid        (ex_valid),
        .instruction_in  (instruction_in),
        .alu_in          (alu_in),
        .mem_data_in     (mem_data_in),
        .stall_out       (stall_out),
        .dmem_req        (dmem_req),
        .dmem_we         (dmem_we),
        .dmem_addr       (dmem_addr),
        .dmem_be         (dmem_be),
        .dmem_wdata      (dmem_wdata),
        .dmem_rdata      (dmem_rdata),
        .dmem_ack        (dmem_ack),
        .wb_valid_out    (wb_valid_out),
        .instruction_out (instruction_out),
        .wb_data_out     (wb_data_out),
        .misalign_out    (misalign_out),
        .bus_err_out     (bus_err_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ex_valid = 1'b1; instruction_in = ADDI; alu_in = 32'h5; mem_data_in = 32'h0;
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
        tick();
        tick();
        checks++;
        if ({dmem_req, dmem_we, dmem_be, wb_valid_out, misalign_out, bus_err_out} !== 9'b0) begin
            failures++;
            $display("[TB] FAIL reset_ctrl got req=%b we=%b be=%h wbv=%b mis=%b berr=%b want all 0",
                     dmem_req, dmem_we, dmem_be, wb_valid_out, misalign_out, bus_err_out);
        end
        checks++;
        if (instruction_out !== NOP || wb_data_out !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_data got instr=%h data=%h want %h 0", instruction_out, wb_data_out, NOP);
        end
        rst = 1'b0;
        ex_valid = 1'b0;
        tick();
    endtask

    task automatic test_alu_pass();
        int stallSeen = 0;
        ex_valid = 1'b1; instruction_in = ADDI; alu_in = 32'h5;
        #1;
        if (stall_out) stallSeen++;
        tick();
        if (stall_out) stallSeen++;
        ex_valid = 1'b0;
        checks++;
        if (wb_valid_out !== 1'b1 || wb_data_out !== 32'h5 || instruction_out !== ADDI) begin
            failures++;
            $display("[TB] FAIL alu_pass got wbv=%b data=%h instr=%h want 1 5 %h",
                     wb_valid_out, wb_data_out, instruction_out, ADDI);
        end
        tick();
        checks++;
        if (stallSeen !== 0 || wb_valid_out !== 1'b0 || instruction_out !== NOP) begin
            failures++;
            $display("[TB] FAIL alu_bubble got stalls=%0d wbv=%b instr=%h want 0 0 %h",
                     stallSeen, wb_valid_out, instruction_out, NOP);
        end
    endtask

    task automatic test_load_byte(input logic [31:0] instr, input logic [31:0] expData);
        int stallCount = 0;
        ex_valid = 1'b1; instruction_in = instr; alu_in = 32'h103;
        #1;
        if (stall_out) stallCount++;
        tick();
        checks++;
        if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 32'h100 || dmem_be !== 4'hF) begin
            failures++;
            $display("[TB] FAIL load_req got req=%b we=%b addr=%h be=%h want 1 0 100 f",
                     dmem_req, dmem_we, dmem_addr, dmem_be);
        end
        if (stall_out) stallCount++;
        tick();
        if (stall_out) stallCount++;
        tick();
        dmem_ack = 1'b1; dmem_rdata = 32'h80FF_1234;
        #1;
        if (stall_out) stallCount++;
        tick();
        dmem_ack = 1'b0; ex_valid = 1'b0;
        #1;
        checks++;
        if (stallCount !== 4 || stall_out !== 1'b0 || dmem_req !== 1'b0) begin
            failures++;
            $display("[TB] FAIL load_stall got stalls=%0d stall_now=%b req=%b want 4 0 0",
                     stallCount, stall_out, dmem_req);
        end
        checks++;
        if (wb_valid_out !== 1'b1 || wb_data_out !== expData || instruction_out !== instr) begin
            failures++;
            $display("[TB] FAIL load_data got wbv=%b data=%h instr=%h want 1 %h %h",
                     wb_valid_out, wb_data_out, instruction_out, expData, instr);
        end
        tick();
    endtask

    task automatic test_store();
        ex_valid = 1'b1; instruction_in = I_SH; alu_in = 32'h202; mem_data_in = 32'hDEAD_BEEF;
        tick();
        alu_in = 32'h999; mem_data_in = 32'h0;
        checks++;
        if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 32'h200 ||
            dmem_be !== 4'b1100 || dmem_wdata !== 32'hBEEF_BEEF) begin
            failures++;
            $display("[TB] FAIL sh_req got req=%b we=%b addr=%h be=%b wdata=%h want 1 1 200 1100 beefbeef",
                     dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata);
        end
        tick();
        checks++;
        if (dmem_req !== 1'b1 || dmem_addr !== 32'h200 || dmem_be !== 4'b1100 || dmem_wdata !== 32'hBEEF_BEEF) begin
            failures++;
            $display("[TB] FAIL sh_hold got req=%b addr=%h be=%b wdata=%h want 1 200 1100 beefbeef",
                     dmem_req, dmem_addr, dmem_be, dmem_wdata);
        end
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0; ex_valid = 1'b0;
        checks++;
        if (dmem_req !== 1'b0 || wb_valid_out !== 1'b1 || wb_data_out !== 32'h0 || instruction_out !== I_SH) begin
            failures++;
            $display("[TB] FAIL sh_done got req=%b wbv=%b data=%h instr=%h want 0 1 0 %h",
                     dmem_req, wb_valid_out, wb_data_out, instruction_out, I_SH);
        end
        tick();
        ex_valid = 1'b1; instruction_in = I_SB; alu_in = 32'h601; mem_data_in = 32'h1234_56A5;
        tick();
        checks++;
        if (dmem_addr !== 32'h600 || dmem_be !== 4'b0010 || dmem_wdata !== 32'hA5A5_A5A5) begin
            failures++;
            $display("[TB] FAIL sb_req got addr=%h be=%b wdata=%h want 600 0010 a5a5a5a5",
                     dmem_addr, dmem_be, dmem_wdata);
        end
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0; ex_valid = 1'b0;
        tick();
    endtask

    task automatic test_misalign();
        ex_valid = 1'b1; instruction_in = I_LW; alu_in = 32'h301;
        #1;
        checks++;
        if (stall_out !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mis_stall got %b want 0", stall_out);
        end
        tick();
        instruction_in = I_L11; alu_in = 32'h300;
        checks++;
        if (dmem_req !== 1'b0 || misalign_out !== 1'b1 || wb_valid_out !== 1'b1 ||
            instruction_out !== NOP || wb_data_out !== 32'h301) begin
            failures++;
            $display("[TB] FAIL mis_lw got req=%b mis=%b wbv=%b instr=%h data=%h want 0 1 1 %h 301",
                     dmem_req, misalign_out, wb_valid_out, instruction_out, wb_data_out, NOP);
        end
        tick();
        ex_valid = 1'b0;
        checks++;
        if (dmem_req !== 1'b0 || misalign_out !== 1'b1 || wb_data_out !== 32'h300) begin
            failures++;
            $display("[TB] FAIL mis_f3 got req=%b mis=%b data=%h want 0 1 300",
                     dmem_req, misalign_out, wb_data_out);
        end
        tick();
        checks++;
        if (misalign_out !== 1'b0 || wb_valid_out !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mis_pulse got mis=%b wbv=%b want 0 0", misalign_out, wb_valid_out);
        end
    endtask

    task automatic test_timeout();
        int reqCount = 0;
        int errCount = 0;
        ex_valid = 1'b1; instruction_in = I_LW; alu_in = 32'h400;
        tick();
        ex_valid = 1'b0;
        #1;
        for (int i = 0; i < 40; i++) begin
            if (dmem_req) reqCount++;
            if (bus_err_out) begin
                errCount++;
                checks++;
                if (wb_valid_out !== 1'b1 || instruction_out !== NOP || stall_out !== 1'b0 || dmem_req !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL berr_slot got wbv=%b instr=%h stall=%b req=%b want 1 %h 0 0",
                             wb_valid_out, instruction_out, stall_out, dmem_req, NOP);
                end
            end
            tick();
        end
        checks++;
        if (reqCount !== 16 || errCount !== 1) begin
            failures++;
            $display("[TB] FAIL timeout got req_cycles=%0d berr_pulses=%0d want 16 1", reqCount, errCount);
        end
    endtask

    task automatic test_reset_mid();
        ex_valid = 1'b1; instruction_in = I_SW; alu_in = 32'h500; mem_data_in = 32'h1122_3344;
        tick();
        checks++;
        if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_be !== 4'hF || dmem_wdata !== 32'h1122_3344) begin
            failures++;
            $display("[TB] FAIL sw_req got req=%b we=%b be=%h wdata=%h want 1 1 f 11223344",
                     dmem_req, dmem_we, dmem_be, dmem_wdata);
        end
        ex_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({dmem_req, dmem_we, dmem_be, wb_valid_out, misalign_out, bus_err_out, stall_out} !== 10'b0 ||
            instruction_out !== NOP || wb_data_out !== 32'h0) begin
            failures++;
            $display("[TB] FAIL mid_reset got req=%b we=%b be=%h wbv=%b stall=%b instr=%h data=%h",
                     dmem_req, dmem_we, dmem_be, wb_valid_out, stall_out, instruction_out, wb_data_out);
        end
        tick();
        dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        tick();
        dmem_ack = 1'b0;
        checks++;
        if (wb_valid_out !== 1'b0 || dmem_req !== 1'b0 || instruction_out !== NOP || stall_out !== 1'b0) begin
            failures++;
            $display("[TB] FAIL stray_ack got wbv=%b req=%b instr=%h stall=%b want 0 0 %h 0",
                     wb_valid_out, dmem_req, instruction_out, stall_out, NOP);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        ex_valid = 1'b1; instruction_in = I_LW; alu_in = 32'h10;
        tick();
        dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
        tick();
        dmem_ack = 1'b0; instruction_in = I_LHU; alu_in = 32'h12;
        #1;
        checks++;
        if (wb_valid_out !== 1'b1 || wb_data_out !== 32'h1234_5678 || stall_out !== 1'b1) begin
            failures++;
            $display("[TB] FAIL b2b_first got wbv=%b data=%h stall=%b want 1 12345678 1",
                     wb_valid_out, wb_data_out, stall_out);
        end
        tick();
        checks++;
        if (dmem_req !== 1'b1 || dmem_addr !== 32'h10 || wb_valid_out !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_req got req=%b addr=%h wbv=%b want 1 10 0", dmem_req, dmem_addr, wb_valid_out);
        end
        dmem_ack = 1'b1; dmem_rdata = 32'hABCD_0000;
        tick();
        dmem_ack = 1'b0; ex_valid = 1'b0;
        checks++;
        if (wb_valid_out !== 1'b1 || wb_data_out !== 32'h0000_ABCD || instruction_out !== I_LHU) begin
            failures++;
            $display("[TB] FAIL b2b_lhu got wbv=%b data=%h instr=%h want 1 0000abcd %h",
                     wb_valid_out, wb_data_out, instruction_out, I_LHU);
        end
        tick();
    endtask

    // Scenarios run in sequence; each leaves the DUT idle with ex_valid low.
    initial begin
        test_reset();
        test_alu_pass();
        test_load_byte(I_LB, 32'hFFFF_FF80);
        test_load_byte(I_LBU, 32'h0000_0080);
        test_store();
        test_misalign();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_mem_access.md
Name: instr_mem_access

Overview:
- Memory-access stage of the RV32I pipeline. It sits between the execute stage and write-back.
- Consumes the execute-stage outputs: instruction, ALU result (effective address or result), and store data.
- For LOAD/STORE it runs a request/acknowledge transaction on the data-memory port. It stalls upstream until that transaction completes.
- Loads are sign- or zero-extended; stores are lane-aligned. Non-memory results pass through with one-cycle latency.

Parameters:
- XLEN, 32, datapath width.
- TIMEOUT, 16, maximum cycles waiting for dmem_ack before bus error (≥2).
- NOP, 32'h0000_0013, instruction_out value after reset, bubble or fault.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- ex_valid  in  1  execute-stage outputs valid this cycle.
- instruction_in  in  XLEN  instruction from execute.
- alu_in  in  XLEN  ALU result or effective address.
- mem_data_in  in  XLEN  store data (rs2) from execute.
- stall_out  out  1  upstream must hold its outputs stable; combinational.
- dmem_req  out  1  memory request.
- dmem_we  out  1  1 = write.
- dmem_addr  out  XLEN  word address {alu_in[31:2],2'b00}.
- dmem_be  out  4  byte enables.
- dmem_wdata  out  XLEN  lane-aligned write data.
- dmem_rdata  in  XLEN  read data, valid with dmem_ack.
- dmem_ack  in  1  transaction complete.
- wb_valid_out  out  1  write-back slot valid.
- instruction_out  out  XLEN  instruction to write-back.
- wb_data_out  out  XLEN  result to write-back.
- misalign_out  out  1  misaligned access or illegal funct3 (one-cycle pulse with wb_valid_out).
- bus_err_out  out  1  dmem timeout (one-cycle pulse).

Behaviour:
- Reset (rst high at posedge) forces the following, overriding everything:
  - state = IDLE, timeout counter = 0.
  - dmem_req = 0, dmem_we = 0, dmem_be = 0.
  - wb_valid_out = 0, misalign_out = 0, bus_err_out = 0, wb_data_out = 0, instruction_out = NOP.
  - A reset asserted mid-transaction abandons it; any ack after reset is ignored in IDLE.
- Decode uses opcode instruction_in[6:0]: LOAD = 0000011, STORE = 0100011. funct3 = [14:12].
  - Loads: LB 000, LH 001, LW 010, LBU 100, LHU 101.
  - Stores: SB 000, SH 001, SW 010.
  - Other funct3 values are illegal.
- Alignment: halfword requires addr[0] = 0; word requires addr[1:0] = 0.
- FSM states: IDLE, BUSY.
- IDLE, ex_valid = 0:
  - Next cycle: wb_valid_out = 0, instruction_out = NOP.
- IDLE, ex_valid = 1, non-memory opcode:
  - Next cycle: wb_valid_out = 1, instruction_out = instruction_in, wb_data_out = alu_in.
  - stall_out = 0.
- IDLE, ex_valid = 1, memory op misaligned or illegal:
  - No request issued.
  - Next cycle: wb_valid_out = 1, misalign_out = 1, instruction_out = NOP, wb_data_out = alu_in (faulting address).
- IDLE, ex_valid = 1, legal memory op:
  - stall_out = 1 combinationally this cycle.
  - Request fields are registered: dmem_req = 1, dmem_we = STORE, dmem_addr, dmem_be, dmem_wdata. Go to BUSY, counter = 0.
- Store lane rules:
  - SB: be = 4'b0001 << addr[1:0], wdata = {4{rs2[7:0]}}.
  - SH: be = 4'b0011 << addr[1:0], wdata = {2{rs2[15:0]}}.
  - SW: be = 4'b1111, wdata = rs2.
  - Loads: be = 4'b1111, wdata = 0.
- BUSY:
  - stall_out = 1, and dmem_req and all request fields held constant. The counter increments each cycle without ack.
  - On dmem_ack the next cycle gives: dmem_req = 0, state = IDLE, wb_valid_out = 1, instruction_out = latched instruction, stall_out released.
    - Load: wb_data_out = extracted lane, selected by latched addr[1:0]. Byte lane = rdata[8*a+7:8*a]; halfword lane = rdata[16*a[1]+15:16*a[1]]. LB/LH sign-extend, LBU/LHU zero-extend, LW is the full word.
    - Store: wb_data_out = 0.
  - Timeout: when the counter reaches TIMEOUT-1 without ack, the next cycle gives dmem_req = 0, IDLE, wb_valid_out = 1, bus_err_out = 1, instruction_out = NOP.
  - Ack and timeout in the same cycle: ack wins.
- Latency: 1 cycle for non-memory ops. For memory ops, N+1 cycles from acceptance, where N = cycles until ack.
- Back-to-back memory ops: the first cycle after return to IDLE may accept the next op. There is no dead cycle beyond that.
- dmem_ack in IDLE is ignored.

Test Plan:
- Reset, then ADDI with alu_in = 32'h5, ex_valid = 1 -> next cycle wb_valid_out = 1, wb_data_out = 5, stall_out never high. During rst all outputs are at reset values.
- LB at alu_in = 32'h103, ack after 3 cycles with rdata = 32'h80FF_1234 -> dmem_addr = 32'h100, be = 4'hF, stall high 4 cycles, wb_data_out = 32'hFFFF_FF80. The same access with LBU gives 32'h0000_0080.
- SH at alu_in = 32'h202, rs2 = 32'hDEAD_BEEF -> dmem_we = 1, be = 4'b1100, wdata = 32'hBEEF_BEEF, request held until ack, wb_data_out = 0.
- LW at alu_in = 32'h301 -> no dmem_req, next cycle misalign_out = 1, instruction_out = NOP, wb_data_out = 32'h301.
- LW with no ack and TIMEOUT = 16 -> dmem_req high exactly 16 cycles, then bus_err_out pulses once and stall_out drops.
- SW in BUSY with rst asserted for 1 cycle, then ack 2 cycles later -> all outputs at reset values, the stray ack is ignored, and wb_valid_out stays 0.
